// File: rtl/tms_io_responder.sv
// tms_io_responder: board-side R/O/K responder for the TMS1000 soft core.
// Answers R-strobe scans with K lines from a key-matrix bitmap and latches the
// multiplexed O-segment pattern of each strobed R line into a per-digit latch.
// Ports:
//   raw_clk        - sole clock
//   button_reset   - synchronous active-low reset
//   pins_r         - R strobes from the core (NUM_DIGITS bits)
//   pins_o         - O segment lines from the core (8 bits)
//   key_matrix     - pressed keys, bit r*4+k joins R line r to K line k
//   pins_k         - K lines returned to the core (4 bits)
//   digit_index    - readback digit select (4 bits)
//   digit_segments - latched segments of the selected digit
//   digit_valid    - selected digit holds a live capture
//   update_pulse   - one-cycle strobe on every digit latch write
// Optional feature: define TMS_IO_AGING_EN to build per-digit age counters that
// invalidate a digit after REFRESH_TIMEOUT cycles without a refresh.
module tms_io_responder #(
    parameter int NUM_DIGITS      = 11,
    parameter int SETTLE_CYCLES   = 8,
    parameter int REFRESH_TIMEOUT = 65535
) (
    input  logic                    raw_clk,
    input  logic                    button_reset,
    input  logic [NUM_DIGITS-1:0]   pins_r,
    input  logic [7:0]              pins_o,
    input  logic [4*NUM_DIGITS-1:0] key_matrix,
    output logic [3:0]              pins_k,
    input  logic [3:0]              digit_index,
    output logic [7:0]              digit_segments,
    output logic                    digit_valid,
    output logic                    update_pulse
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [4:0] ND = 5'(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, SETTLE, LATCHED} state_t;

    state_t                r_state, w_next;
    logic [NUM_DIGITS-1:0] r_r_m, r_r_s, r_cap_r;
    logic [7:0]            r_o_m, r_o_s, r_cap_o;
    logic [3:0]            r_cap_idx, w_idx, w_k;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_valid;
    logic                  w_onehot, w_same, w_load, w_write;

    always_comb begin
        w_k   = '0;
        w_idx = '0;
        for (int r = 0; r < NUM_DIGITS; r++) begin
            if (r_r_s[r]) begin
                w_k   = w_k | key_matrix[r*4 +: 4];
                w_idx = 4'(r);
            end
        end
    end

    // Zero or multi-hot R never starts a capture.
    assign w_onehot = (r_r_s != '0) && ((r_r_s & (r_r_s - 1'b1)) == '0);
    assign w_same   = (r_r_s == r_cap_r) && (r_o_s == r_cap_o);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = w_onehot;
                w_next = w_onehot ? SETTLE : IDLE;
            end
            SETTLE: begin
                w_write = w_same && (r_cnt == CW'(SETTLE_CYCLES - 1));
                w_next  = !w_same ? IDLE : (w_write ? LATCHED : SETTLE);
            end
            LATCHED: w_next = w_same ? LATCHED : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (!button_reset) begin
            r_state   <= IDLE;
            r_r_m     <= '0;
            r_r_s     <= '0;
            r_o_m     <= '0;
            r_o_s     <= '0;
            r_cap_r   <= '0;
            r_cap_o   <= '0;
            r_cap_idx <= '0;
            r_cnt     <= '0;
            pins_k    <= '0;
        end else begin
            r_state <= w_next;
            r_r_m   <= pins_r;
            r_r_s   <= r_r_m;
            r_o_m   <= pins_o;
            r_o_s   <= r_o_m;
            pins_k  <= w_k;
            if (w_load) begin
                r_cap_r   <= r_r_s;
                r_cap_o   <= r_o_s;
                r_cap_idx <= w_idx;
                r_cnt     <= '0;
            end else if (r_state == SETTLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef TMS_IO_AGING_EN
    localparam int AW = $clog2(REFRESH_TIMEOUT + 1);
    logic [AW-1:0] r_age [NUM_DIGITS];
`endif

    always_ff @(posedge raw_clk) begin
        if (!button_reset) begin
            r_digit      <= '{default: '0};
            r_valid      <= '0;
            update_pulse <= 1'b0;
`ifdef TMS_IO_AGING_EN
            r_age        <= '{default: '0};
`endif
        end else begin
            update_pulse <= w_write;
`ifdef TMS_IO_AGING_EN
            // valid drops on the same edge the age saturates at the timeout
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (r_valid[d] && r_age[d] != AW'(REFRESH_TIMEOUT)) begin
                    r_age[d] <= r_age[d] + 1'b1;
                    if (r_age[d] == AW'(REFRESH_TIMEOUT - 1))
                        r_valid[d] <= 1'b0;
                end
            end
`endif
            // placed after the aging loop so a write beats a same-cycle expiry
            if (w_write) begin
                r_digit[r_cap_idx] <= r_cap_o;
                r_valid[r_cap_idx] <= 1'b1;
`ifdef TMS_IO_AGING_EN
                r_age[r_cap_idx]   <= '0;
`endif
            end
        end
    end

    always_ff @(posedge raw_clk) begin
        if (!button_reset) begin
            digit_segments <= '0;
            digit_valid    <= 1'b0;
        end else begin
            digit_segments <= ({1'b0, digit_index} < ND) ? r_digit[digit_index] : '0;
            digit_valid    <= ({1'b0, digit_index} < ND) ? r_valid[digit_index] : 1'b0;
        end
    end
endmodule

// File: tb/tb_tms_io_responder.sv
// tb_tms_io_responder: directed self-checking bench for tms_io_responder.
module tb_tms_io_responder;
    localparam int ND = 11;
    localparam int S  = 8;
    localparam int T  = 100;

    logic            raw_clk = 1'b0;
    logic            button_reset;
    logic [ND-1:0]   pins_r;
    logic [7:0]      pins_o;
    logic [4*ND-1:0] key_matrix;
    logic [3:0]      pins_k;
    logic [3:0]      digit_index;
    logic [7:0]      digit_segments;
    logic            digit_valid;
    logic            update_pulse;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;
    int   base;

    tms_io_responder #(
        .NUM_DIGITS(ND),
        .SETTLE_CYCLES(S),
        .REFRESH_TIMEOUT(T)
    ) dut (
        .raw_clk(raw_clk),
        .button_reset(button_reset),
        .pins_r(pins_r),
        .pins_o(pins_o),
        .key_matrix(key_matrix),
        .pins_k(pins_k),
        .digit_index(digit_index),
        .digit_segments(digit_segments),
        .digit_valid(digit_valid),
        .update_pulse(update_pulse)
    );

    always #5 raw_clk = ~raw_clk;

    always @(posedge raw_clk) if (update_pulse === 1'b1) pulse_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] idx, input logic [7:0] seg);
        exp_t e;
        e.idx = idx;
        e.seg = seg;
        exp_q.push_back(e);
        digit_index = idx;
    endtask

    task automatic wait_write(input string tag);
        int   k;
        exp_t e;
        k = 0;
        do begin
            @(negedge raw_clk);
            k++;
        end while (update_pulse !== 1'b1 && k < 40);
        chk({tag, "_latency"}, k, S + 3);
        @(negedge raw_clk);
        chk({tag, "_pulse_width"}, update_pulse, 0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_seg"}, digit_segments, e.seg);
            chk({tag, "_valid"}, digit_valid, 1);
        end
    endtask

    initial begin
        button_reset = 1'b0;
        pins_r       = 11'h001;
        pins_o       = 8'h7E;
        key_matrix   = '1;
        digit_index  = 4'd0;

        // reset hold
        repeat (4) begin
            @(negedge raw_clk);
            chk("rst_pins_k", pins_k, 0);
            chk("rst_segments", digit_segments, 0);
            chk("rst_valid", digit_valid, 0);
            chk("rst_pulse", update_pulse, 0);
        end
        expect_write(4'd0, 8'h7E);
        button_reset = 1'b1;
        wait_write("rst_release");

        // key scan
        pins_r = '0;
        repeat (4) @(negedge raw_clk);
        chk("k_idle", pins_k, 0);
        key_matrix     = '0;
        key_matrix[14] = 1'b1;
        pins_r         = 11'h008;
        repeat (2) @(negedge raw_clk);
        chk("k_before_latency", pins_k, 0);
        @(negedge raw_clk);
        chk("k_row3", pins_k, 4'b0100);
        key_matrix[0] = 1'b1;
        pins_r        = 11'h009;
        repeat (3) @(negedge raw_clk);
        chk("k_ghost", pins_k, 4'b0101);
        pins_r = '0;
        repeat (3) @(negedge raw_clk);
        chk("k_zero", pins_k, 0);
        repeat (2) @(negedge raw_clk);
        chk("k_no_write", pulse_cnt, 1);

        // digit capture
        base   = pulse_cnt;
        pins_o = 8'h30;
        pins_r = 11'h004;
        expect_write(4'd2, 8'h30);
        wait_write("cap_d2");
        repeat (8) @(negedge raw_clk);
        chk("cap_single_write", pulse_cnt - base, 1);
        digit_index = 4'd12;
        @(negedge raw_clk);
        chk("idx12_seg", digit_segments, 0);
        chk("idx12_valid", digit_valid, 0);
        digit_index = 4'd2;
        @(negedge raw_clk);
        chk("idx2_seg", digit_segments, 8'h30);
        chk("idx2_valid", digit_valid, 1);

        // glitch reject: O toggles faster than the settle window
        pins_r = '0;
        repeat (4) @(negedge raw_clk);
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            pins_o = i[0] ? 8'h6D : 8'h30;
            pins_r = 11'h004;
            repeat (4) @(negedge raw_clk);
        end
        pins_r = '0;
        repeat (4) @(negedge raw_clk);
        chk("glitch_o_no_write", pulse_cnt - base, 0);
        pins_o = 8'h30;
        pins_r = 11'h005;
        repeat (50) @(negedge raw_clk);
        pins_r = '0;
        repeat (4) @(negedge raw_clk);
        chk("multihot_no_write", pulse_cnt - base, 0);

        // reset in the middle of a settle window
        base        = pulse_cnt;
        digit_index = 4'd1;
        pins_o      = 8'h11;
        pins_r      = 11'h002;
        repeat (6) @(negedge raw_clk);
        button_reset = 1'b0;
        pins_r       = '0;
        @(negedge raw_clk);
        button_reset = 1'b1;
        repeat (15) @(negedge raw_clk);
        chk("mid_settle_no_write", pulse_cnt - base, 0);
        chk("mid_settle_d1_valid", digit_valid, 0);
        digit_index = 4'd2;
        @(negedge raw_clk);
        chk("rst_cleared_d2_seg", digit_segments, 0);
        chk("rst_cleared_d2_valid", digit_valid, 0);

        // aging
        pins_o = 8'h3F;
        pins_r = 11'h001;
        expect_write(4'd0, 8'h3F);
        wait_write("age_d0");
        pins_r = '0;
        repeat (99) @(negedge raw_clk);
        chk("age_hold", digit_valid, 1);
        @(negedge raw_clk);
`ifdef TMS_IO_AGING_EN
        chk("age_expire", digit_valid, 0);
        chk("age_seg_kept", digit_segments, 8'h3F);
        pins_r = 11'h001;
        expect_write(4'd0, 8'h3F);
        wait_write("age_relatch_a");
        pins_r = '0;
        repeat (88) @(negedge raw_clk);
        pins_o = 8'h5B;
        pins_r = 11'h001;
        expect_write(4'd0, 8'h5B);
        wait_write("age_relatch_expiry");
        repeat (2) @(negedge raw_clk);
        chk("age_write_wins", digit_valid, 1);
`else
        chk("no_age_valid", digit_valid, 1);
        repeat (60) @(negedge raw_clk);
        chk("no_age_valid_late", digit_valid, 1);
        chk("no_age_seg", digit_segments, 8'h3F);
`endif
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tms_io_responder.md
# tms_io_responder

Board-side responder for the TMS1000 soft core's R/O/K pin interface. It plays the role of the calculator or game hardware around the chip. It answers R-strobe scans by driving K lines from a key-matrix bitmap. It captures the multiplexed O-segment pattern for each strobed R line into a per-digit display latch that the board can read back. It sits between the core's `pins_r`/`pins_o` outputs and its `pins_k` input.

## Interface
Parameters:
- `NUM_DIGITS`, 11: number of R lines and display digit latches (1–11).
- `SETTLE_CYCLES`, 8: cycles that R and O must be unchanged before a digit latches (≥1).
- `REFRESH_TIMEOUT`, 65535: cycles without refresh before a digit is invalidated. Used only when aging is compiled in.

Ports:
- `raw_clk`  in  1  sole clock for all logic.
- `button_reset`  in  1  synchronous, active-low reset.
- `pins_r`  in  NUM_DIGITS  R strobes from the core.
- `pins_o`  in  8  O segment lines from the core.
- `key_matrix`  in  4*NUM_DIGITS  pressed keys, active-high; bit `r*4+k` is the key joining R line r to K line k.
- `pins_k`  out  4  K lines returned to the core.
- `digit_index`  in  4  readback digit select.
- `digit_segments`  out  8  latched segments of the selected digit.
- `digit_valid`  out  1  selected digit holds a live capture.
- `update_pulse`  out  1  one-cycle strobe on every digit latch write.

## Operation
- **Input sync:** `pins_r` and `pins_o` pass through two flops; all logic below uses the synced copies (`r_s`, `o_s`). `key_matrix` and `digit_index` are used directly.
- **K response:** each cycle, `pins_k` is registered as the OR, over every r with `r_s[r]` set, of `key_matrix[r*4 +: 4]`.
  - `r_s` = 0 gives `pins_k` = 0.
  - Multi-hot R ORs all strobed rows, which reproduces real ghosting.
- **Capture FSM:**
  - **IDLE:** if `r_s` is exactly one-hot with index < NUM_DIGITS, store `cap_r` = `r_s`, `cap_o` = `o_s`, set count = 0, go to SETTLE. Otherwise stay (zero or multi-hot R never captures).
  - **SETTLE:**
    - If `r_s` ≠ `cap_r` or `o_s` ≠ `cap_o`, go to IDLE with no write.
    - Else if count = SETTLE_CYCLES−1: write `digit[idx]` = `cap_o`, set `valid[idx]` = 1, clear `age[idx]`, assert `update_pulse`, go to LATCHED.
    - Else increment count.
  - **LATCHED:** stay until `r_s` ≠ `cap_r` or `o_s` ≠ `cap_o`, then go to IDLE. A held strobe is written exactly once.
- **Readback:** `digit_segments`/`digit_valid` are registered from `digit[digit_index]`/`valid[digit_index]`. A `digit_index` ≥ NUM_DIGITS returns 0/0.
- **Aging (when enabled):**
  - Each valid digit's `age` increments every cycle and saturates.
  - When `age` reaches REFRESH_TIMEOUT, `valid` is cleared; segment data is kept.
  - If a latch write and an expiry hit the same digit in the same cycle, the write wins: `valid` = 1, `age` = 0.

## Timing
- Reset (while `button_reset` = 0 at a `raw_clk` edge):
  - Outputs: `pins_k` = 0, `digit_segments` = 0, `digit_valid` = 0, `update_pulse` = 0.
  - Internal: all `digit` = 0, `valid` = 0, `age` = 0, sync flops = 0, FSM in IDLE.
  - Reset mid-SETTLE discards the capture with no write.
- K latency: 3 cycles from a `pins_r` change (2 sync + 1 output register). This is far below the core's 64-cycle instruction-state period.
- Latch latency: with R/O stable from edge N, `update_pulse` is high in cycle N+SETTLE_CYCLES+3 (2 sync + 1 IDLE→SETTLE + SETTLE_CYCLES).
- `update_pulse` is high for exactly 1 cycle per write.
- Readback latency: 1 cycle after a `digit_index` change or a latch write.
- Expiry: `digit_valid` drops REFRESH_TIMEOUT cycles after the last write to that digit, plus 1 for the readback register.

## Configuration
- `TMS_IO_AGING_EN` defined: age counters and expiry are present as described.
- Undefined: no age counters are built, and a digit stays valid from its first latch until reset. REFRESH_TIMEOUT is ignored.

## Test plan
- **Reset hold:** hold `button_reset` = 0 for 4 cycles with R=11'h001, O=8'h7E, keys all set. All outputs stay 0; after release, the first `update_pulse` occurs SETTLE_CYCLES+3 cycles later.
- **Key scan:** `key_matrix` bit 4*3+2 = 1, R=11'h008, so `pins_k` = 4'b0100 three cycles later. R=11'h000 gives `pins_k` = 0. R=11'h009 with bit 0*4+0 also set gives 4'b0101.
- **Digit capture:** R=11'h004, O=8'h30 held for 20 cycles gives one `update_pulse` and digit 2 = 8'h30, valid. Reading `digit_index`=2 returns 8'h30/1. Reading `digit_index`=12 returns 0/0.
- **Glitch reject:**
  - O toggles 8'h30→8'h6D→8'h30 with a period below SETTLE_CYCLES: no write.
  - R=11'h005 (multi-hot) held for 50 cycles: no write.
- **Aging (`TMS_IO_AGING_EN`, REFRESH_TIMEOUT=100):** latch digit 0, then hold R=0. `digit_valid` for index 0 drops 101 cycles after the write. Re-latching on the expiry cycle keeps it valid. Without the macro it stays valid.
